// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the multi-cycle execute-stage ALU.
//   - bit positions of the one-hot aluSignals op vector
//   - top-level FSM state type
//   - iterative engine operation select and step count
package seq_alu_pkg;

    localparam int OP_W   = 15;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;
    localparam int OP_MOD = 4;
    localparam int OP_CMP = 5;
    localparam int OP_AND = 6;
    localparam int OP_OR  = 7;
    localparam int OP_NOT = 8;
    localparam int OP_MOV = 9;
    localparam int OP_LSL = 10;
    localparam int OP_LSR = 11;
    localparam int OP_ASR = 12;
    localparam int OP_LD  = 13;
    localparam int OP_ST  = 14;

    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } seq_alu_state_t;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_MOD = 2'd2
    } md_op_t;

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: 32-step iterative multiply / signed divide / signed modulo.
//   clk, rst   : clock, async active-high reset
//   start_i    : latch operands and begin; ignored while busy
//   kind_i     : MD_MUL, MD_DIV or MD_MOD
//   a_i, b_i   : operands (b_i must be nonzero for div/mod)
//   last_o     : high during the final step; res_o is valid on that cycle
//   res_o      : result as it will stand after the current step
// Multiply is shift-add on the raw operands (low 32 bits are sign-agnostic).
// Divide is restoring division on magnitudes followed by a sign fix.
module seq_muldiv
    import seq_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  md_op_t      kind_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        last_o,
    output logic [31:0] res_o
);

    md_op_t      kind_q, kind_d;
    logic [31:0] acc_q, acc_d;    // product accumulator / partial remainder
    logic [31:0] opnd_q, opnd_d;  // shifted multiplicand / dividend->quotient
    logic [31:0] aux_q, aux_d;    // shifted multiplier / divisor magnitude
    logic        neg_q, neg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [32:0] r_sh;
    logic [32:0] diff;
    logic [31:0] q_nx;
    logic [31:0] r_nx;
    logic [31:0] p_nx;

    assign last_o = busy_q && (cnt_q == 5'(STEPS - 1));

    always_comb begin
        r_sh = {acc_q, opnd_q[31]};
        diff = r_sh - {1'b0, aux_q};
        // diff is in (-divisor, divisor), so bit 32 is a reliable sign
        q_nx = {opnd_q[30:0], ~diff[32]};
        r_nx = diff[32] ? r_sh[31:0] : diff[31:0];
        p_nx = acc_q + (aux_q[0] ? opnd_q : 32'd0);

        case (kind_q)
            MD_DIV:  res_o = neg_q ? (32'd0 - q_nx) : q_nx;
            MD_MOD:  res_o = neg_q ? (32'd0 - r_nx) : r_nx;
            default: res_o = p_nx;
        endcase

        kind_d = kind_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        aux_d  = aux_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (busy_q) begin
            cnt_d = cnt_q + 5'd1;
            if (last_o) busy_d = 1'b0;
            if (kind_q == MD_MUL) begin
                acc_d  = p_nx;
                opnd_d = {opnd_q[30:0], 1'b0};
                aux_d  = {1'b0, aux_q[31:1]};
            end else begin
                acc_d  = r_nx;
                opnd_d = q_nx;
            end
        end else if (start_i) begin
            kind_d = kind_i;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            if (kind_i == MD_MUL) begin
                opnd_d = a_i;
                aux_d  = b_i;
                neg_d  = 1'b0;
            end else begin
                // 0x80000000 negates to itself, which is its correct unsigned magnitude
                opnd_d = a_i[31] ? (32'd0 - a_i) : a_i;
                aux_d  = b_i[31] ? (32'd0 - b_i) : b_i;
                neg_d  = (kind_i == MD_DIV) ? (a_i[31] ^ b_i[31]) : a_i[31];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q <= MD_MUL;
            acc_q  <= '0;
            opnd_q <= '0;
            aux_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            kind_q <= kind_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            aux_q  <= aux_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU with registered result and cmp flags.
//   clk, rst    : clock, async active-high reset
//   start       : request, accepted when start && ready
//   aluSignals  : one-hot op vector (bit positions in seq_alu_pkg)
//   op_a, op_b  : operands
//   ready       : can accept (IDLE or DONE)
//   done        : one-cycle completion pulse; result/err valid with it
//   result      : registered result, held until the next done
//   flag_e      : a == b, updated only by cmp
//   flag_gt     : signed a > b, updated only by cmp
//   err         : illegal vector, divide by zero, or mul/div/mod not built
// Build option SEQ_ALU_MULDIV_EN: when defined, mul/div/mod run on the
// 32-step seq_muldiv engine; otherwise they complete at once with err set.
//
// state | meaning
// IDLE  | waiting for a request
// ITER  | iterative engine running (mul/div/mod)
// DONE  | done pulse; may accept the next request
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  aluSignals,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_e,
    output logic             flag_gt,
    output logic             err
);

    seq_alu_state_t state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_e_q, flag_e_d;
    logic             flag_gt_q, flag_gt_d;
    logic             err_q, err_d;

    logic             multi_hot;
    logic             is_nop;
    logic             is_md;
    logic [WIDTH-1:0] simple_res;
    logic             md_last;
    logic [WIDTH-1:0] md_res;

    assign multi_hot = |(aluSignals & (aluSignals - 15'd1));
    assign is_nop    = (aluSignals == '0);
    assign is_md     = aluSignals[OP_MUL] | aluSignals[OP_DIV] | aluSignals[OP_MOD];

`ifdef SEQ_ALU_MULDIV_EN
    logic   md_start;
    md_op_t md_kind;

    assign md_kind = aluSignals[OP_MUL] ? MD_MUL :
                     aluSignals[OP_DIV] ? MD_DIV : MD_MOD;

    seq_muldiv u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .kind_i  (md_kind),
        .a_i     (op_a),
        .b_i     (op_b),
        .last_o  (md_last),
        .res_o   (md_res)
    );
`else
    assign md_last = 1'b0;
    assign md_res  = '0;
`endif

    always_comb begin
        simple_res = '0;
        case (1'b1)
            aluSignals[OP_ADD], aluSignals[OP_LD], aluSignals[OP_ST]:
                simple_res = op_a + op_b;
            aluSignals[OP_SUB], aluSignals[OP_CMP]:
                simple_res = op_a - op_b;
            aluSignals[OP_AND]: simple_res = op_a & op_b;
            aluSignals[OP_OR]:  simple_res = op_a | op_b;
            aluSignals[OP_NOT]: simple_res = ~op_b;
            aluSignals[OP_MOV]: simple_res = op_b;
            aluSignals[OP_LSL]: simple_res = op_a << op_b[4:0];
            aluSignals[OP_LSR]: simple_res = op_a >> op_b[4:0];
            aluSignals[OP_ASR]: simple_res = $signed(op_a) >>> op_b[4:0];
            default:            simple_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        result_d  = result_q;
        flag_e_d  = flag_e_q;
        flag_gt_d = flag_gt_q;
        err_d     = err_q;
`ifdef SEQ_ALU_MULDIV_EN
        md_start  = 1'b0;
`endif

        if (state_q == S_ITER) begin
            if (md_last) begin
                result_d = md_res;
                err_d    = 1'b0;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
        end else if (start) begin
            done_d   = 1'b1;
            state_d  = S_DONE;
            result_d = '0;
            err_d    = 1'b0;
            if (multi_hot) begin
                err_d = 1'b1;
            end else if (is_nop) begin
                err_d = 1'b0;
            end else if (is_md) begin
`ifdef SEQ_ALU_MULDIV_EN
                if (!aluSignals[OP_MUL] && (op_b == '0)) begin
                    err_d = 1'b1;
                end else begin
                    // result stays held until the engine finishes
                    result_d = result_q;
                    err_d    = err_q;
                    done_d   = 1'b0;
                    md_start = 1'b1;
                    state_d  = S_ITER;
                end
`else
                err_d = 1'b1;
`endif
            end else begin
                result_d = simple_res;
                if (aluSignals[OP_CMP]) begin
                    flag_e_d  = (op_a == op_b);
                    flag_gt_d = ($signed(op_a) > $signed(op_b));
                end
            end
        end else begin
            state_d = S_IDLE;
        end

        ready_d = (state_d != S_ITER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            result_q  <= result_d;
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
            err_q     <= err_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign result  = result_q;
    assign flag_e  = flag_e_q;
    assign flag_gt = flag_gt_q;
    assign err     = err_q;

endmodule
